shake_absorb_buffer: RTL and testbench

// Rate-block assembler between the SHAKE FIFO reader and the Keccak core.

---
 rtl/shake_absorb_buffer.sv | 119 +++++++++++
 tb/tb_shake_absorb_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shake_absorb_buffer.sv
// SHAKE rate-block assembler: packs 64-bit words into one rate block, applies
// 0x1F..0x80 padding and hands the block to the Keccak core over valid/ready.
module shake_absorb_buffer #(
  parameter int          LANE_W    = 64,
  parameter int          LANES_128 = 21,
  parameter int          LANES_256 = 17,
  parameter logic [7:0]  DS_BYTE   = 8'h1F
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        module_start,
  input  logic [1:0]                  mode,
  input  logic [LANE_W-1:0]           shake_in,
  input  logic                        in_ready,
  input  logic                        is_last,
  input  logic [2:0]                  byte_num,
  output logic                        i_last,
  output logic                        buffer_full,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic [LANE_W*LANES_128-1:0] blk_data,
  output logic                        blk_final,
  output logic                        ovf_err
);

  localparam int CNT_W = $clog2(LANES_128);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t                             state, state_nxt;
  logic [LANES_128-1:0][LANE_W-1:0]   lanes;
  logic [CNT_W-1:0]                   lane_cnt;
  logic [CNT_W-1:0]                   last_lane;
  logic                               rate_128;
  logic                               at_last;
  logic [LANE_W-1:0]                  pad;
  logic                               unused_mode;

  assign unused_mode = mode[1];
  assign last_lane   = rate_128 ? CNT_W'(LANES_128 - 1) : CNT_W'(LANES_256 - 1);
  assign at_last     = (lane_cnt == last_lane);
  assign blk_data    = lanes;
  assign blk_valid   = (state == FULL);
  assign buffer_full = (state == FULL);
  assign i_last      = ~rst & in_ready & ~is_last & (state == FILL) & at_last;

  // Final word: keep the first byte_num bytes, then the domain byte, then zeros.
  always_comb begin
    pad = '0;
    for (int k = 0; k < LANE_W / 8; k++) begin
      if (k < int'(byte_num))
        pad[LANE_W-1-8*k -: 8] = shake_in[LANE_W-1-8*k -: 8];
      else if (k == int'(byte_num))
        pad[LANE_W-1-8*k -: 8] = DS_BYTE;
    end
  end

  always_comb begin
    state_nxt = state;
    if (module_start) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (in_ready && (is_last || at_last)) state_nxt = FULL;
        FULL:    if (blk_ready) state_nxt = blk_final ? IDLE : FILL;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lanes     <= '0;
      lane_cnt  <= '0;
      rate_128  <= 1'b0;
      blk_final <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (module_start) begin
        lanes     <= '0;
        lane_cnt  <= '0;
        blk_final <= 1'b0;
        rate_128  <= mode[0];
      end else begin
        case (state)
          FILL: begin
            if (in_ready) begin
              if (is_last) begin
                blk_final <= 1'b1;
                // Lanes above lane_cnt are still zero, so a plain write equals the OR.
                if (at_last) begin
                  lanes[lane_cnt] <= pad | LANE_W'(8'h80);
                end else begin
                  lanes[lane_cnt]  <= pad;
                  lanes[last_lane] <= LANE_W'(8'h80);
                end
              end else begin
                lanes[lane_cnt] <= shake_in;
                if (!at_last) lane_cnt <= lane_cnt + 1'b1;
              end
            end
          end
          FULL: begin
            if (in_ready) ovf_err <= 1'b1;
            if (blk_ready) begin
              lanes     <= '0;
              lane_cnt  <= '0;
              blk_final <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shake_absorb_buffer.sv
// Bench for shake_absorb_buffer: directed table, corner sequences and random
// messages checked against a byte-level sponge padding model.
module tb_shake_absorb_buffer;

  logic          clk = 1'b0;
  logic          rst, module_start;
  logic [1:0]    mode;
  logic [63:0]   shake_in;
  logic          in_ready, is_last;
  logic [2:0]    byte_num;
  logic          i_last, buffer_full, blk_valid, blk_ready, blk_final, ovf_err;
  logic [1343:0] blk_data;

  shake_absorb_buffer dut (
    .clk(clk), .rst(rst), .module_start(module_start), .mode(mode),
    .shake_in(shake_in), .in_ready(in_ready), .is_last(is_last), .byte_num(byte_num),
    .i_last(i_last), .buffer_full(buffer_full), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_final(blk_final), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            ilast_cnt;
  logic [1343:0] got_q[$];
  logic [1343:0] exp_q[$];
  bit            gotf_q[$];

  typedef struct {
    bit          md;
    int          nfull;
    logic [2:0]  nb;
    logic [63:0] lw;
    int          exp_blocks;
    int          exp_ilast;
    logic [63:0] exp_lane0;
    logic [63:0] exp_top;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] fw(input int i);
    return 64'h0102030405060708 + 64'(i) * 64'h1010101010101010;
  endfunction

  // Sponge padding on the byte stream: msg || 0x1F || 0.. , last byte |= 0x80.
  task automatic build_model(input bit md, input logic [63:0] wq[$], input logic [2:0] nb,
                             input logic [63:0] lw);
    logic [7:0]    bq[$];
    logic [1343:0] blk;
    int rate, bb;
    rate = md ? 21 : 17;
    bb   = rate * 8;
    foreach (wq[i]) for (int k = 0; k < 8; k++) bq.push_back(wq[i][63-8*k -: 8]);
    for (int k = 0; k < int'(nb); k++) bq.push_back(lw[63-8*k -: 8]);
    bq.push_back(8'h1F);
    while (bq.size() % bb != 0) bq.push_back(8'h00);
    bq[bq.size()-1] = bq[bq.size()-1] | 8'h80;
    exp_q.delete();
    for (int b = 0; b < bq.size() / bb; b++) begin
      blk = '0;
      for (int i = 0; i < rate; i++)
        for (int k = 0; k < 8; k++) blk[64*i+63-8*k -: 8] = bq[b*bb + i*8 + k];
      exp_q.push_back(blk);
    end
  endtask

  task automatic take_block(input int hold);
    logic [1343:0] snap;
    snap = blk_data;
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      chk("hold_valid", 64'(blk_valid), 64'd1);
      chk("hold_stable", 64'(blk_data == snap), 64'd1);
    end
    got_q.push_back(blk_data);
    gotf_q.push_back(blk_final);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w, input bit last, input logic [2:0] nb,
                           input bit auto_take, input int hold);
    shake_in = w; in_ready = 1'b1; is_last = last; byte_num = nb;
    #1;
    if (i_last) ilast_cnt++;
    @(negedge clk);
    in_ready = 1'b0; is_last = 1'b0; shake_in = {$urandom, $urandom};
    if (auto_take && buffer_full) take_block(hold);
  endtask

  task automatic start_msg(input bit md);
    mode = {1'($urandom), md};
    module_start = 1'b1;
    @(negedge clk);
    module_start = 1'b0;
  endtask

  task automatic run_msg(input bit md, input int nfull, input logic [2:0] nb,
                         input logic [63:0] lw, input bit rnd);
    logic [63:0] wq[$];
    int nexp;
    got_q.delete(); gotf_q.delete(); ilast_cnt = 0;
    for (int i = 0; i < nfull; i++) wq.push_back(rnd ? {$urandom, $urandom} : fw(i));
    start_msg(md);
    foreach (wq[i]) begin
      send_word(wq[i], 1'b0, 3'($urandom), 1'b1, rnd ? int'($urandom_range(0, 20)) : 0);
      if (rnd && ($urandom % 4 == 0)) @(negedge clk);
    end
    send_word(lw, 1'b1, nb, 1'b1, rnd ? int'($urandom_range(0, 20)) : 0);
    build_model(md, wq, nb, lw);
    nexp = exp_q.size();
    chk("blk_count", 64'(got_q.size()), 64'(nexp));
    chk("ilast_count", 64'(ilast_cnt), 64'(nexp - 1));
    for (int b = 0; b < nexp && b < got_q.size(); b++) begin
      chk($sformatf("blk%0d_final", b), 64'(gotf_q[b]), 64'(b == nexp - 1));
      for (int i = 0; i < 21; i++)
        chk($sformatf("blk%0d_lane%0d", b, i), got_q[b][64*i +: 64], exp_q[b][64*i +: 64]);
    end
    chk("idle_after_msg", 64'(buffer_full), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1343:0] snap;
    vecs[0] = '{1'b0, 0,  3'd3, 64'hAABBCCDDEEFF0011, 1, 0, 64'hAABBCC1F00000000, 64'h80};
    vecs[1] = '{1'b0, 1,  3'd0, 64'h0,                1, 0, 64'h0102030405060708, 64'h80};
    vecs[2] = '{1'b1, 21, 3'd0, 64'h0,                2, 1, 64'h1F00000000000000, 64'h80};
    vecs[3] = '{1'b0, 16, 3'd7, 64'h1122334455667700, 1, 0, 64'h0102030405060708, 64'h112233445566779F};
    vecs[4] = '{1'b1, 20, 3'd7, 64'hCAFEBABE12345600, 1, 0, 64'h0102030405060708, 64'hCAFEBABE1234569F};

    rst = 1'b1; module_start = 0; mode = 0; shake_in = 0; in_ready = 0; is_last = 0;
    byte_num = 0; blk_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_blk_valid", 64'(blk_valid), 64'd0);
    chk("rst_blk_final", 64'(blk_final), 64'd0);
    chk("rst_buffer_full", 64'(buffer_full), 64'd0);
    chk("rst_ovf_err", 64'(ovf_err), 64'd0);
    chk("rst_blk_data", 64'(blk_data != '0), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Words offered while IDLE are ignored without error.
    send_word(64'hFFFF, 1'b1, 3'd2, 1'b0, 0);
    chk("idle_word_full", 64'(buffer_full), 64'd0);
    chk("idle_word_ovf", 64'(ovf_err), 64'd0);

    foreach (vecs[v]) begin
      run_msg(vecs[v].md, vecs[v].nfull, vecs[v].nb, vecs[v].lw, 1'b0);
      chk($sformatf("tbl%0d_blocks", v), 64'(got_q.size()), 64'(vecs[v].exp_blocks));
      chk($sformatf("tbl%0d_ilast", v), 64'(ilast_cnt), 64'(vecs[v].exp_ilast));
      if (got_q.size() > 0) begin
        chk($sformatf("tbl%0d_lane0", v), got_q[$][63:0], vecs[v].exp_lane0);
        chk($sformatf("tbl%0d_top", v),
            got_q[$][64*(vecs[v].md ? 20 : 16) +: 64], vecs[v].exp_top);
        chk($sformatf("tbl%0d_final", v), 64'(gotf_q[$]), 64'd1);
      end
    end

    // Overflow: block held for 40 cycles, a word arrives while FULL.
    got_q.delete(); gotf_q.delete();
    start_msg(1'b0);
    send_word(64'h5500000000000000, 1'b1, 3'd1, 1'b0, 0);
    chk("ovf_pre", 64'(ovf_err), 64'd0);
    snap = blk_data;
    for (int c = 0; c < 40; c++) begin
      if (c == 10) begin shake_in = 64'hDEADBEEFDEADBEEF; in_ready = 1'b1; end
      @(negedge clk);
      in_ready = 1'b0;
    end
    chk("ovf_err", 64'(ovf_err), 64'd1);
    chk("ovf_valid", 64'(blk_valid), 64'd1);
    chk("ovf_data_kept", 64'(blk_data == snap), 64'd1);
    chk("ovf_lane0", blk_data[63:0], 64'h551F000000000000);
    take_block(0);
    chk("ovf_sticky", 64'(ovf_err), 64'd1);

    // module_start while FULL abandons the block and restarts from lane 0.
    start_msg(1'b0);
    send_word(64'h7777777777777777, 1'b0, 3'd0, 1'b0, 0);
    send_word(64'h1234000000000000, 1'b1, 3'd2, 1'b0, 0);
    chk("ms_full", 64'(blk_valid), 64'd1);
    start_msg(1'b1);
    chk("ms_valid_drop", 64'(blk_valid), 64'd0);
    chk("ms_not_full", 64'(buffer_full), 64'd0);
    got_q.delete(); gotf_q.delete();
    send_word(64'hABCD000000000000, 1'b1, 3'd2, 1'b1, 0);
    if (got_q.size() > 0) begin
      chk("ms_lane0", got_q[0][63:0], 64'hABCD1F0000000000);
      chk("ms_lane1", got_q[0][127:64], 64'h0);
      chk("ms_lane20", got_q[0][64*20 +: 64], 64'h80);
    end else chk("ms_block", 64'd0, 64'd1);

    // Reset mid-FILL with i_last active: everything drops at once.
    start_msg(1'b0);
    for (int i = 0; i < 16; i++) send_word(fw(i), 1'b0, 3'd0, 1'b0, 0);
    shake_in = 64'h1111; in_ready = 1'b1; is_last = 1'b0;
    #1;
    chk("pre_rst_ilast", 64'(i_last), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_ilast", 64'(i_last), 64'd0);
    chk("rst_mid_data", 64'(blk_data != '0), 64'd0);
    chk("rst_mid_valid", 64'(blk_valid), 64'd0);
    chk("rst_mid_ovf", 64'(ovf_err), 64'd0);
    chk("rst_mid_full", 64'(buffer_full), 64'd0);
    @(negedge clk);
    in_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 30; t++)
      run_msg(1'($urandom), int'($urandom_range(0, 45)), 3'($urandom), {$urandom, $urandom}, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
